// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit owning the HI/LO pair.
// One multiplier/quotient bit per cycle, then a sign-fixup cycle that commits HI/LO.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic en);
        return en ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v, input logic en);
        return en ? -v : v;
    endfunction

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opd_q, opd_d;
    logic               is_div_q, is_div_d;
    logic               qneg_q, qneg_d;
    logic               rneg_q, rneg_d;
    logic               dz_q, dz_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic signed [WIDTH-1:0] a_s, b_s;
    logic                    sgn_op, a_neg, b_neg;
    logic [WIDTH-1:0]        a_mag, b_mag;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fixed;

    assign a_s    = a;
    assign b_s    = b;
    assign sgn_op = op[0];
    assign a_neg  = sgn_op && (a_s < 0);
    assign b_neg  = sgn_op && (b_s < 0);
    assign a_mag  = neg_w(a, a_neg);
    assign b_mag  = neg_w(b, b_neg);

    // Shift-add: acc = {partial product, remaining multiplier bits}.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opd_q : {WIDTH{1'b0}})};
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring divide: acc = {partial remainder, dividend bits / quotient bits}.
    assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, opd_q};
    assign div_rem   = div_ge ? WIDTH'(div_shift - {1'b0, opd_q}) : div_shift[WIDTH-1:0];
    assign div_next  = {div_rem, acc_q[WIDTH-2:0], div_ge};

    assign prod_fixed = neg_2w(acc_q, qneg_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opd_d    = opd_q;
        is_div_d = is_div_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (!op[2]) begin
                        state_d  = S_CALC;
                        cnt_d    = CW'(WIDTH - 1);
                        is_div_d = op[1];
                        qneg_d   = a_neg ^ b_neg;
                        rneg_d   = a_neg;
                        dz_d     = op[1] && (b == '0);
                        acc_d    = {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
                        opd_d    = op[1] ? b_mag : a_mag;
                    end else if (op == OP_MTHI) begin
                        hi_d = a;
                    end else if (op == OP_MTLO) begin
                        lo_d = a;
                    end
                end
            end
            S_CALC: begin
                acc_d = is_div_q ? div_next : mul_next;
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_FIX: begin
                if (is_div_q && dz_q) begin
                    // With a zero divisor the remainder field ends up holding |a|;
                    // undoing the magnitude restores the raw dividend.
                    hi_d = neg_w(acc_q[2*WIDTH-1:WIDTH], rneg_q);
                    lo_d = '1;
                end else if (is_div_q) begin
                    hi_d = neg_w(acc_q[2*WIDTH-1:WIDTH], rneg_q);
                    lo_d = neg_w(acc_q[WIDTH-1:0], qneg_q);
                end else begin
                    hi_d = prod_fixed[2*WIDTH-1:WIDTH];
                    lo_d = prod_fixed[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opd_q    <= '0;
            is_div_q <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opd_q    <= opd_d;
            is_div_q <= is_div_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            dz_q     <= dz_d;
            done_q   <= done_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit (WIDTH = 32) with hand-computed results.
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int n_cmp = 0;
    int n_bad = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Launch an op, then wait (bounded) for done; reports latency, busy gaps and any HI/LO change mid-run.
    task automatic do_op(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                         output int lat, output int busy_gap, output int hl_chg,
                         output logic [W-1:0] h, output logic [W-1:0] l);
        logic [W-1:0] h0, l0;
        bit           seen;
        @(negedge clk);
        start = 1'b1; op = o; a = av; b = bv;
        @(posedge clk); #1;
        start = 1'b0;
        h0 = hi; l0 = lo;
        lat = 0; busy_gap = busy ? 0 : 1; hl_chg = 0; seen = 1'b0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat  = i;
                seen = 1'b1;
            end else begin
                if (!busy) busy_gap++;
                if (hi !== h0 || lo !== l0) hl_chg++;
            end
        end
        h = hi; l = lo;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; op = 3'b000; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy actual=%b required=0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done actual=%b required=0", done); end
        n_cmp++; if (hi !== 32'h0) begin n_bad++; $display("FAIL reset_hi actual=%h required=0", hi); end
        n_cmp++; if (lo !== 32'h0) begin n_bad++; $display("FAIL reset_lo actual=%h required=0", lo); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_multu;
        int lat, gap, chg;
        logic [W-1:0] h, l;
        do_op(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, gap, chg, h, l);
        n_cmp++; if (lat != 33) begin n_bad++; $display("FAIL multu_latency actual=%0d required=33", lat); end
        n_cmp++; if (h !== 32'hFFFFFFFE) begin n_bad++; $display("FAIL multu_hi actual=%h required=fffffffe", h); end
        n_cmp++; if (l !== 32'h00000001) begin n_bad++; $display("FAIL multu_lo actual=%h required=00000001", l); end
        n_cmp++; if (gap != 0) begin n_bad++; $display("FAIL multu_busy_gaps actual=%0d required=0", gap); end
        n_cmp++; if (chg != 0) begin n_bad++; $display("FAIL multu_hilo_early actual=%0d required=0", chg); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL multu_busy_on_done actual=%b required=0", busy); end
        @(posedge clk); #1;
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL multu_done_width actual=%b required=0", done); end
    endtask

    task automatic test_mult;
        int lat, gap, chg;
        logic [W-1:0] h, l;
        do_op(3'b001, 32'hFFFFFFFE, 32'h00000003, lat, gap, chg, h, l);
        n_cmp++; if (h !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL mult_neg_hi actual=%h required=ffffffff", h); end
        n_cmp++; if (l !== 32'hFFFFFFFA) begin n_bad++; $display("FAIL mult_neg_lo actual=%h required=fffffffa", l); end
        do_op(3'b001, 32'h80000000, 32'h80000000, lat, gap, chg, h, l);
        n_cmp++; if (h !== 32'h40000000) begin n_bad++; $display("FAIL mult_minmin_hi actual=%h required=40000000", h); end
        n_cmp++; if (l !== 32'h00000000) begin n_bad++; $display("FAIL mult_minmin_lo actual=%h required=00000000", l); end
        n_cmp++; if (lat != 33) begin n_bad++; $display("FAIL mult_latency actual=%0d required=33", lat); end
    endtask

    task automatic test_div;
        int lat, gap, chg;
        logic [W-1:0] h, l;
        do_op(3'b010, 32'd7, 32'd2, lat, gap, chg, h, l);
        n_cmp++; if (l !== 32'd3) begin n_bad++; $display("FAIL divu_q actual=%h required=00000003", l); end
        n_cmp++; if (h !== 32'd1) begin n_bad++; $display("FAIL divu_r actual=%h required=00000001", h); end
        do_op(3'b011, 32'hFFFFFFF9, 32'd2, lat, gap, chg, h, l);
        n_cmp++; if (l !== 32'hFFFFFFFD) begin n_bad++; $display("FAIL div_neg_q actual=%h required=fffffffd", l); end
        n_cmp++; if (h !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL div_neg_r actual=%h required=ffffffff", h); end
        do_op(3'b011, 32'h80000000, 32'hFFFFFFFF, lat, gap, chg, h, l);
        n_cmp++; if (l !== 32'h80000000) begin n_bad++; $display("FAIL div_ovf_q actual=%h required=80000000", l); end
        n_cmp++; if (h !== 32'h00000000) begin n_bad++; $display("FAIL div_ovf_r actual=%h required=00000000", h); end
        n_cmp++; if (lat != 33) begin n_bad++; $display("FAIL div_latency actual=%0d required=33", lat); end
    endtask

    task automatic test_div_zero;
        int lat, gap, chg;
        logic [W-1:0] h, l;
        do_op(3'b010, 32'h00001234, 32'h0, lat, gap, chg, h, l);
        n_cmp++; if (h !== 32'h00001234) begin n_bad++; $display("FAIL divu0_hi actual=%h required=00001234", h); end
        n_cmp++; if (l !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL divu0_lo actual=%h required=ffffffff", l); end
        do_op(3'b011, 32'hFFFFFFF0, 32'h0, lat, gap, chg, h, l);
        n_cmp++; if (h !== 32'hFFFFFFF0) begin n_bad++; $display("FAIL div0_hi actual=%h required=fffffff0", h); end
        n_cmp++; if (l !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL div0_lo actual=%h required=ffffffff", l); end
    endtask

    task automatic test_mthi_mtlo;
        @(negedge clk);
        start = 1'b1; op = 3'b100; a = 32'hDEADBEEF; b = 32'h0;
        @(posedge clk); #1;
        start = 1'b0;
        n_cmp++; if (hi !== 32'hDEADBEEF) begin n_bad++; $display("FAIL mthi_hi actual=%h required=deadbeef", hi); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mthi_busy actual=%b required=0", busy); end
        @(negedge clk);
        start = 1'b1; op = 3'b101; a = 32'h0BADF00D;
        @(posedge clk); #1;
        start = 1'b0;
        n_cmp++; if (lo !== 32'h0BADF00D) begin n_bad++; $display("FAIL mtlo_lo actual=%h required=0badf00d", lo); end
        n_cmp++; if (hi !== 32'hDEADBEEF) begin n_bad++; $display("FAIL mtlo_hi_kept actual=%h required=deadbeef", hi); end
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL mtlo_handshake actual=%b%b required=00", busy, done); end
        // Reserved ops must not disturb anything.
        @(negedge clk);
        start = 1'b1; op = 3'b110; a = 32'h12345678;
        @(posedge clk); #1;
        start = 1'b0;
        n_cmp++; if (busy !== 1'b0 || hi !== 32'hDEADBEEF || lo !== 32'h0BADF00D) begin
            n_bad++; $display("FAIL noop_ignored actual=%b/%h/%h required=0/deadbeef/0badf00d", busy, hi, lo);
        end
    endtask

    task automatic test_ignore_while_busy;
        int lat;
        bit seen;
        @(negedge clk);
        start = 1'b1; op = 3'b000; a = 32'd3; b = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; seen = 1'b0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            if (i == 5) begin
                start = 1'b1; op = 3'b000; a = 32'd7; b = 32'd9;
            end else if (i == 6) begin
                start = 1'b1; op = 3'b100; a = 32'h0000AAAA;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done) begin lat = i; seen = 1'b1; end
        end
        start = 1'b0;
        n_cmp++; if (lat != 33) begin n_bad++; $display("FAIL busy_ignore_latency actual=%0d required=33", lat); end
        n_cmp++; if (hi !== 32'd0) begin n_bad++; $display("FAIL busy_ignore_hi actual=%h required=00000000", hi); end
        n_cmp++; if (lo !== 32'd15) begin n_bad++; $display("FAIL busy_ignore_lo actual=%h required=0000000f", lo); end
    endtask

    task automatic test_back_to_back;
        int lat, gap, chg;
        logic [W-1:0] h, l;
        bit seen;
        do_op(3'b000, 32'd6, 32'd7, lat, gap, chg, h, l);
        n_cmp++; if (l !== 32'd42 || h !== 32'd0) begin n_bad++; $display("FAIL b2b_first actual=%h_%h required=00000000_0000002a", h, l); end
        // Still inside the done cycle: issue the next op immediately.
        start = 1'b1; op = 3'b010; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_accept actual=%b required=1", busy); end
        lat = 0; seen = 1'b0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(posedge clk); #1;
            if (done) begin lat = i; seen = 1'b1; end
        end
        n_cmp++; if (lat != 33) begin n_bad++; $display("FAIL b2b_latency actual=%0d required=33", lat); end
        n_cmp++; if (lo !== 32'd14 || hi !== 32'd2) begin n_bad++; $display("FAIL b2b_second actual=%h_%h required=00000002_0000000e", hi, lo); end
    endtask

    task automatic test_reset_abort;
        int dones;
        @(negedge clk);
        start = 1'b1; op = 3'b011; a = 32'd100; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL abort_handshake actual=%b%b required=00", busy, done); end
        n_cmp++; if (hi !== 32'h0 || lo !== 32'h0) begin n_bad++; $display("FAIL abort_hilo actual=%h_%h required=00000000_00000000", hi, lo); end
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done || busy) dones++;
        end
        n_cmp++; if (dones != 0) begin n_bad++; $display("FAIL abort_no_done actual=%0d required=0", dones); end
    endtask

    initial begin
        test_reset;
        test_multu;
        test_mult;
        test_div;
        test_div_zero;
        test_mthi_mtlo;
        test_ignore_while_busy;
        test_back_to_back;
        test_reset_abort;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised multi-cycle multiply/divide unit owning the HI/LO register pair, the sequential successor to the single-cycle ALU multiply path. It sits beside the ALU in the execute stage and runs MULT/MULTU/DIV/DIVU as a radix-2 iterative datapath over WIDTH cycles, with a start/busy/done handshake toward the control unit. It also services MTHI/MTLO writes. HI/LO read-back is continuous via the `hi`/`lo` outputs.

## Interface
- WIDTH, 32: operand, HI and LO width; legal range ≥ 4.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  request; sampled only when `busy` = 0.
- op  in  3  000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO; 110/111 no-op.
- a  in  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO data).
- b  in  WIDTH  rt operand (divisor / multiplier).
- busy  out  1  high while an arithmetic op is in flight.
- done  out  1  single-cycle pulse on the cycle HI/LO first show a new arithmetic result.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

## Operation
- States: IDLE, CALC, FIX. `busy` = (state != IDLE).
- IDLE + start + op ∈ {000..011}: latch operands and op, go to CALC with iteration counter = WIDTH-1.
- Signed ops (MULT, DIV): latch magnitudes |a|, |b|. Record the sign flags: product/quotient sign = a[MSB]^b[MSB]; remainder sign = a[MSB].
- Multiply: shift-add over a 2·WIDTH accumulator, one multiplier bit per cycle.
- Divide: restoring division, one quotient bit per cycle; remainder in the upper half.
- CALC with counter = 0: go to FIX; otherwise decrement the counter.
- FIX: apply the sign fixup (two's-complement negate where the flag is set), write HI/LO, assert `done`, return to IDLE.
- Multiply result: hi = product[2·WIDTH-1:WIDTH], lo = product[WIDTH-1:0].
- Divide result: lo = quotient, hi = remainder. Remainder takes the sign of the dividend, quotient truncates toward zero.
- Signed overflow: most-negative ÷ −1 gives lo = most-negative, hi = 0. This is the natural wrap; no trap is raised.
- Divide by zero (b = 0, DIVU or DIV): hi = a (raw, unsigned), lo = all ones. This is fixed behaviour, and the sign fixup is bypassed.
- IDLE + start + MTHI/MTLO: hi (or lo) ← a at that edge. No state change, no `busy`, no `done`.
- op 110/111 with start: ignored.
- start while busy (any op, including MTHI/MTLO): ignored; operands are not re-latched.
- HI/LO keep their old values throughout CALC and change only in FIX.

## Timing
- Reset values: state IDLE, busy 0, done 0, hi 0, lo 0, counter 0. Reset asserted mid-operation aborts immediately and asynchronously; no `done` is issued.
- Arithmetic op accepted at edge E0. `busy` is high from E0 through edge E(WIDTH+1).
- HI/LO are updated and `done` goes high at edge E(WIDTH+1), i.e. WIDTH+1 cycles after acceptance (33 for WIDTH = 32).
- `busy` is low in the same cycle that `done` is high, so a back-to-back start is accepted on that cycle.
- MTHI/MTLO take effect at the accepting edge; the value is visible on `hi`/`lo` in the following cycle.
- `done` is never high for two consecutive cycles.

## Test plan
- Unsigned multiply: MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → after exactly 33 cycles, done=1, hi=0xFFFFFFFE, lo=0x00000001; busy high for the 33 intervening edges.
- Signed multiply: MULT a=0xFFFFFFFE, b=0x00000003 → hi=0xFFFFFFFF, lo=0xFFFFFFFA. Then MULT 0x80000000 × 0x80000000 → hi=0x40000000, lo=0.
- Division: DIVU 7/2 → lo=3, hi=1. DIV 0xFFFFFFF9/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- Divide by zero: DIVU a=0x00001234, b=0 → hi=0x00001234, lo=0xFFFFFFFF. DIV a=0xFFFFFFF0, b=0 → hi=0xFFFFFFF0, lo=0xFFFFFFFF.
- Handshake: a second start (MULTU, and separately MTHI) issued mid-CALC → ignored, first result unchanged. A start on the done cycle → accepted, with a second done 33 cycles later.
- MTHI/MTLO and reset: MTHI a=0xDEADBEEF, then MTLO a=0x0BADF00D → hi/lo show these values one cycle later, busy stays 0. Reset asserted 10 cycles into a DIV → busy=0, done=0, hi=lo=0 immediately, and no done pulse afterwards.
